uart_tx_arbiter: RTL

//  Shares one uart_tx + baud_rate_generator pair among NREQ byte requesters.

---
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares a single uart_tx / baud_rate_generator pair among NREQ byte
//   requesters. Requesters are served round-robin. A granted byte is accepted
//   with a one-cycle req_ready pulse. The byte is then launched with a
//   one-cycle tx_start pulse. The arbiter waits for tx_done_tick, and a
//   watchdog abandons the frame if the tick never arrives. The arbiter also
//   owns the baud divisor. Divisor writes are applied only between frames.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/data    per-requester byte offer (byte i at [i*DBIT +: DBIT])
//   req_ready         one-hot accept pulse to the granted requester
//   cfg_wr/value      divisor write port
//   final_value       divisor driven to the baud generator
//   baud_enable       baud generator enable (START..WAIT only)
//   tx_start/tx_din   frame launch pulse and byte to uart_tx
//   tx_done_tick      frame-complete pulse from uart_tx
//   busy              high whenever the arbiter is not idle
//   grant_id          current / last granted requester
//   tx_err            one-cycle pulse when the watchdog expires
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int DBIT     = 8,
    parameter int WIDTH    = 10,
    parameter int FV_RESET = 650,
    parameter int TIMEOUT  = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DBIT-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      cfg_wr,
    input  logic [WIDTH-1:0]          cfg_final_value,
    output logic [WIDTH-1:0]          final_value,
    output logic                      baud_enable,
    output logic                      tx_start,
    output logic [DBIT-1:0]           tx_din,
    input  logic                      tx_done_tick,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      tx_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] REQ_ONE   = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]  ID_LAST   = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t             state_r;
    logic [IDW-1:0]     rr_ptr_r;
    logic [WIDTH-1:0]   pending_r;
    logic               pending_valid_r;
    logic [WDW-1:0]     wdog_r;

    logic [IDW-1:0]     winner_s;
    logic               any_valid_s;
    logic [IDW-1:0]     scan_idx_s;
    logic [IDW-1:0]     next_ptr_s;

    // Round-robin pick: scan from the highest offset down so the requester
    // closest to rr_ptr (offset 0) is the last writer and therefore wins.
    always_comb begin
        winner_s    = {IDW{1'b0}};
        any_valid_s = 1'b0;
        scan_idx_s  = {IDW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan_idx_s = IDW'((int'(rr_ptr_r) + i) % NREQ);
            if (req_valid[scan_idx_s]) begin
                winner_s    = scan_idx_s;
                any_valid_s = 1'b1;
            end else begin
                winner_s    = winner_s;
                any_valid_s = any_valid_s;
            end
        end
    end

    // Pointer position after the current grant finishes (wraps at NREQ).
    always_comb begin
        if (grant_id == ID_LAST) begin
            next_ptr_s = {IDW{1'b0}};
        end else begin
            next_ptr_s = grant_id + IDW'(1);
        end
    end

    // Arbiter FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            rr_ptr_r        <= {IDW{1'b0}};
            pending_r       <= {WIDTH{1'b0}};
            pending_valid_r <= 1'b0;
            wdog_r          <= {WDW{1'b0}};
            req_ready       <= {NREQ{1'b0}};
            final_value     <= WIDTH'(FV_RESET);
            baud_enable     <= 1'b0;
            tx_start        <= 1'b0;
            tx_din          <= {DBIT{1'b0}};
            busy            <= 1'b0;
            grant_id        <= {IDW{1'b0}};
            tx_err          <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one state.
            req_ready <= {NREQ{1'b0}};
            tx_start  <= 1'b0;
            tx_err    <= 1'b0;

            // Divisor only moves between frames; writes during a frame are
            // parked in pending (last write wins) and applied at the next idle.
            if (state_r == ST_IDLE) begin
                if (cfg_wr) begin
                    final_value <= cfg_final_value;
                end else if (pending_valid_r) begin
                    final_value <= pending_r;
                end
                pending_valid_r <= 1'b0;
            end else if (cfg_wr) begin
                pending_r       <= cfg_final_value;
                pending_valid_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        grant_id  <= winner_s;
                        req_ready <= REQ_ONE << winner_s;
                        busy      <= 1'b1;
                        state_r   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Byte is taken even if valid has dropped meanwhile.
                    tx_din      <= req_data[int'(grant_id) * DBIT +: DBIT];
                    tx_start    <= 1'b1;
                    baud_enable <= 1'b1;
                    state_r     <= ST_START;
                end
                ST_START: begin
                    wdog_r  <= {WDW{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done_tick) begin
                        rr_ptr_r    <= next_ptr_s;
                        baud_enable <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (wdog_r == WDOG_LAST) begin
                        tx_err      <= 1'b1;
                        rr_ptr_r    <= next_ptr_s;
                        baud_enable <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        wdog_r <= wdog_r + WDW'(1);
                    end
                end
                default: begin
                    baud_enable <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
